mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: byte-address width of every address port.
REQ-002 Parameter DATA_W, default 32: data width of every data port.
REQ-003 Parameter PROT_TOP, default 32'h0000_0400: DMA writes to addresses below this value are rejected (instruction region).
REQ-004 Port list, one port per line: name, direction, width, meaning.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; level held until cpu_ack.
- cpu_we  in  1  CPU write (1) or read (0); stable while cpu_req is high.
- cpu_addr  in  ADDR_W  CPU address; stable while cpu_req is high.
- cpu_wdata  in  DATA_W  CPU write data; stable while cpu_req is high.
- cpu_ack  out  1  one-cycle pulse: CPU access performed this cycle.
- cpu_rdata  out  DATA_W  registered CPU read data.
- dma_req, dma_we, dma_addr, dma_wdata  in  1/1/ADDR_W/DATA_W  loader port; same rules as the CPU signals.
- dma_ack  out  1  one-cycle pulse: DMA access performed this cycle.
- dma_err  out  1  one-cycle pulse: DMA write rejected by protection.
- dma_rdata  out  DATA_W  registered DMA read data.
- mem_addr  out  ADDR_W  to shared instruction/data memory.
- mem_wdata  out  DATA_W  to shared memory.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_rdata  in  DATA_W  combinational read data from memory.
- cpu_stall  out  1  high while cpu_req is high and cpu_ack is low.

Function
REQ-005 The FSM SHALL have three states: IDLE, GNT_CPU, GNT_DMA.
REQ-006 In IDLE, the FSM SHALL move to GNT_CPU if only cpu_req is high, and to GNT_DMA if only dma_req is high.
REQ-007 In IDLE with both requests high, the FSM SHALL grant the requester that did not receive the most recent grant (round-robin bit last_dma); the CPU wins the first tie after reset.
REQ-008 In IDLE with no request, the FSM SHALL stay in IDLE; mem_read, mem_write and both acks SHALL be 0.
REQ-009 GNT_CPU and GNT_DMA SHALL each last exactly one cycle and always return to IDLE; one access completes every 2 cycles, request-to-ack latency is 1 cycle when the requester wins.
REQ-010 In GNT_x, mem_addr and mem_wdata SHALL equal x's addr and wdata, mem_read SHALL equal !x_we, and mem_write SHALL equal x_we; outside GNT states mem_addr and mem_wdata SHALL be 0.
REQ-011 In GNT_x, x_ack SHALL be 1 and last_dma SHALL update at the clock edge ending the state.
REQ-012 On a read in GNT_x, x_rdata SHALL capture mem_rdata at the clock edge ending the state and hold it until x's next read.
REQ-013 In GNT_DMA with dma_we=1 and dma_addr < PROT_TOP (unsigned), mem_write SHALL be 0, dma_err SHALL be 1, and dma_ack SHALL be 0; the grant still counts for round-robin.
REQ-014 A requester holding req high through its ack cycle SHALL be treated as a new request in the following IDLE.
REQ-015 A request dropped before it is granted SHALL be ignored; no ack or error SHALL be issued for it.
REQ-016 mem_read and mem_write SHALL never both be 1.

Reset
REQ-017 While reset=0, asynchronously: state=IDLE, last_dma=1 (CPU wins the first tie), cpu_rdata=dma_rdata=0, and all strobes, acks and dma_err=0.
REQ-018 If reset asserts during a GNT state, the access SHALL be abandoned with no ack and no rdata update; after reset releases, the first active clock edge SHALL evaluate IDLE.

Verification
REQ-019 CPU read alone: cpu_req=1, cpu_we=0, addr=0x10, mem_rdata=0xDEADBEEF -> cpu_ack in cycle 1, cpu_rdata=0xDEADBEEF in cycle 2, cpu_stall=1 only in cycle 0.
REQ-020 Simultaneous held requests from reset: grants alternate CPU, DMA, CPU, DMA; each ack is followed by one IDLE cycle.
REQ-021 DMA write addr=0x3FC, data=0x1234 -> dma_err=1, mem_write=0, no dma_ack; addr=0x400 -> mem_write=1, dma_ack=1.
REQ-022 CPU write addr=0x20, data=0xA5A5A5A5 -> mem_write=1, mem_read=0, mem_addr=0x20, mem_wdata=0xA5A5A5A5 for exactly one cycle.
REQ-023 Reset pulsed low while in GNT_DMA -> no dma_ack; outputs return to reset values immediately; dma_rdata stays 0.
REQ-024 cpu_req pulsed for one cycle while DMA is granted, then dropped -> no cpu_ack ever issued.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one memory between a CPU and a DMA loader.
// Round-robin on ties, one-cycle grants, and write protection for the DMA below PROT_TOP.
module mem_port_arbiter #(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter logic [31:0] PROT_TOP = 32'h0000_0400
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic              dma_err,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_stall
);

  typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_DMA} state_t;

  state_t state, state_next;
  logic   last_dma;
  logic   dma_protected;

  // Widen both sides so the compare stays unsigned whatever ADDR_W is.
  assign dma_protected = dma_we && (64'(dma_addr) < 64'(PROT_TOP));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case can leave a value held and infer a latch.
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE: begin
        if (cpu_req && dma_req) state_next = last_dma ? GNT_CPU : GNT_DMA;
        else if (cpu_req)       state_next = GNT_CPU;
        else if (dma_req)       state_next = GNT_DMA;
        else                    state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    cpu_ack   = 1'b0;
    dma_ack   = 1'b0;
    dma_err   = 1'b0;
    case (state)
      GNT_CPU: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_read  = !cpu_we;
        mem_write = cpu_we;
        cpu_ack   = 1'b1;
      end
      GNT_DMA: begin
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        mem_read  = !dma_we;
        mem_write = dma_we && !dma_protected;
        dma_err   = dma_protected;
        dma_ack   = !dma_protected;
      end
      default: ;
    endcase
  end

  assign cpu_stall = cpu_req && !cpu_ack;

  // A rejected DMA write still counts as a DMA grant for fairness.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_dma  <= 1'b1;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      if (state == GNT_CPU) begin
        last_dma <= 1'b0;
        if (!cpu_we) cpu_rdata <= mem_rdata;
      end
      if (state == GNT_DMA) begin
        last_dma <= 1'b1;
        if (!dma_we) dma_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reads, writes, round-robin, protection, reset abort.
// Inputs change 1 ns after each rising edge; outputs are checked before the next edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
  logic        cpu_ack, dma_ack, dma_err, mem_read, mem_write, cpu_stall;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_err(dma_err), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .cpu_stall(cpu_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    mem_rdata = 0;

    // Reset state
    #3;
    check("rst_cpu_ack",   32'(cpu_ack),   0);
    check("rst_dma_ack",   32'(dma_ack),   0);
    check("rst_dma_err",   32'(dma_err),   0);
    check("rst_mem_read",  32'(mem_read),  0);
    check("rst_mem_write", 32'(mem_write), 0);
    check("rst_cpu_rdata", cpu_rdata,      0);
    check("rst_dma_rdata", dma_rdata,      0);
    check("rst_mem_addr",  mem_addr,       0);
    #9 reset = 1'b1;
    tick;

    // CPU read alone
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
    #1;
    check("rd_c0_stall", 32'(cpu_stall), 1);
    check("rd_c0_ack",   32'(cpu_ack),   0);
    check("rd_c0_read",  32'(mem_read),  0);
    tick;
    check("rd_c1_ack",   32'(cpu_ack),   1);
    check("rd_c1_read",  32'(mem_read),  1);
    check("rd_c1_write", 32'(mem_write), 0);
    check("rd_c1_addr",  mem_addr,       32'h10);
    check("rd_c1_stall", 32'(cpu_stall), 0);
    check("rd_c1_rdata", cpu_rdata,      0);
    cpu_req = 0;
    tick;
    check("rd_c2_rdata", cpu_rdata,      32'hDEADBEEF);
    check("rd_c2_ack",   32'(cpu_ack),   0);
    check("rd_c2_addr",  mem_addr,       0);
    mem_rdata = 32'h0BADF00D;
    tick;
    check("rd_hold",     cpu_rdata,      32'hDEADBEEF);

    // Round-robin from reset with both requests held
    reset = 0; #2 reset = 1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
    dma_req = 1; dma_we = 0; dma_addr = 32'h200; mem_rdata = 32'h11111111;
    #1;
    check("rr_idle_acks", 32'({cpu_ack, dma_ack}), 0);
    tick;
    check("rr_g1_acks", 32'({cpu_ack, dma_ack}), 32'b10);
    check("rr_g1_addr", mem_addr, 32'h100);
    tick;
    check("rr_i1_acks",  32'({cpu_ack, dma_ack}), 0);
    check("rr_i1_rdata", cpu_rdata, 32'h11111111);
    mem_rdata = 32'h22222222;
    tick;
    check("rr_g2_acks",  32'({cpu_ack, dma_ack}), 32'b01);
    check("rr_g2_addr",  mem_addr, 32'h200);
    check("rr_g2_stall", 32'(cpu_stall), 1);
    tick;
    check("rr_i2_acks",  32'({cpu_ack, dma_ack}), 0);
    check("rr_i2_rdata", dma_rdata, 32'h22222222);
    tick;
    check("rr_g3_acks", 32'({cpu_ack, dma_ack}), 32'b10);
    tick;
    check("rr_i3_acks", 32'({cpu_ack, dma_ack}), 0);
    tick;
    check("rr_g4_acks", 32'({cpu_ack, dma_ack}), 32'b01);
    cpu_req = 0; dma_req = 0;
    tick;
    check("rr_end_acks", 32'({cpu_ack, dma_ack}), 0);

    // DMA write protection boundary
    dma_req = 1; dma_we = 1; dma_addr = 32'h3FC; dma_wdata = 32'h1234;
    tick;
    check("prot_lo_err",   32'(dma_err),   1);
    check("prot_lo_ack",   32'(dma_ack),   0);
    check("prot_lo_write", 32'(mem_write), 0);
    check("prot_lo_read",  32'(mem_read),  0);
    dma_req = 0;
    tick;
    check("prot_idle_err", 32'(dma_err), 0);
    dma_req = 1; dma_addr = 32'h400;
    tick;
    check("prot_hi_write", 32'(mem_write), 1);
    check("prot_hi_ack",   32'(dma_ack),   1);
    check("prot_hi_err",   32'(dma_err),   0);
    check("prot_hi_addr",  mem_addr,       32'h400);
    check("prot_hi_wdata", mem_wdata,      32'h1234);
    dma_req = 0;
    tick;

    // CPU write strobes for exactly one cycle
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'hA5A5A5A5;
    #1;
    check("wr_c0_write", 32'(mem_write), 0);
    tick;
    check("wr_c1_write", 32'(mem_write), 1);
    check("wr_c1_read",  32'(mem_read),  0);
    check("wr_c1_addr",  mem_addr,       32'h20);
    check("wr_c1_wdata", mem_wdata,      32'hA5A5A5A5);
    cpu_req = 0;
    tick;
    check("wr_c2_write", 32'(mem_write), 0);
    check("wr_c2_wdata", mem_wdata,      0);

    // CPU request pulsed only while DMA is granted is never served
    dma_req = 1; dma_we = 0; dma_addr = 32'h500; mem_rdata = 32'h33333333;
    tick;
    check("drop_gnt_dma", 32'(dma_ack), 1);
    cpu_req = 1; cpu_we = 0; dma_req = 0;
    #1;
    check("drop_stall", 32'(cpu_stall), 1);
    tick;
    cpu_req = 0;
    check("drop_dma_rdata", dma_rdata, 32'h33333333);
    for (int i = 0; i < 3; i++) begin
      check("drop_no_ack",  32'(cpu_ack),  0);
      check("drop_no_read", 32'(mem_read), 0);
      tick;
    end

    // Reset asserted in the middle of a DMA grant
    reset = 0; #2 reset = 1;
    dma_req = 1; dma_we = 0; dma_addr = 32'h600; mem_rdata = 32'h44444444;
    tick;
    check("rg_gnt_ack", 32'(dma_ack), 1);
    #2 reset = 0;
    #1;
    check("rg_ack",   32'(dma_ack),  0);
    check("rg_read",  32'(mem_read), 0);
    check("rg_addr",  mem_addr,      0);
    check("rg_rdata", dma_rdata,     0);
    tick;
    check("rg_hold_rdata", dma_rdata, 0);
    #2 reset = 1;
    #1;
    check("rg_rel_ack", 32'(dma_ack), 0);
    tick;
    check("rg_first_grant", 32'(dma_ack), 1);
    dma_req = 0;
    tick;
    check("rg_after_rdata", dma_rdata, 32'h44444444);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
